// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - load/store pipeline stage: address check, byte-lane steering and writeback register
module mem_stage #(
    parameter int WORD_DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_mem_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_wd,
    input  logic        in_wreg,
    input  logic [31:0] in_wdata,
    input  logic        flush,
    output logic        ram_enable,
    output logic        ram_write_en,
    output logic [3:0]  ram_write_sel,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        wb_exc,
    output logic [31:0] wb_badvaddr
);
    localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4, OP_LW = 4'd5;
    localparam logic [3:0] OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t      state_q;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [4:0]  wd_q;
    logic        wreg_q;
    logic        wb_valid_q, wb_wreg_q, wb_exc_q;
    logic [4:0]  wb_wd_q;
    logic [31:0] wb_wdata_q, wb_badvaddr_q;

    logic        is_load, is_store, misaligned, out_of_range, illegal, accept;
    logic        in_access, store_q;
    logic [31:0] lane_shift;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_d;

    assign is_load      = (in_mem_op >= OP_LB) && (in_mem_op <= OP_LW);
    assign is_store     = (in_mem_op >= OP_SB) && (in_mem_op <= OP_SW);
    assign misaligned   = (((in_mem_op == OP_LH) || (in_mem_op == OP_LHU) || (in_mem_op == OP_SH)) && in_addr[0])
                        || (((in_mem_op == OP_LW) || (in_mem_op == OP_SW)) && (in_addr[1:0] != 2'b00));
    assign out_of_range = {2'b00, in_addr[31:2]} >= 32'(WORD_DEPTH);
    assign illegal      = (is_load || is_store) && (misaligned || out_of_range);

    // The WB slot must be free (or draining this edge) before accepting, so ACCESS never stalls.
    assign in_ready = rst && (state_q == S_IDLE) && (!wb_valid_q || wb_ready) && !flush;
    assign accept   = in_valid && in_ready;

    assign in_access  = (state_q == S_ACCESS);
    assign store_q    = (op_q >= OP_SB) && (op_q <= OP_SW);
    assign ram_enable = in_access && !flush;
    assign ram_addr   = in_access ? {2'b00, addr_q[31:2]} : 32'd0;

    always_comb begin
        ram_write_en  = 1'b0;
        ram_write_sel = 4'b0000;
        ram_data_in   = 32'd0;
        if (ram_enable) begin
            case (op_q)
                OP_SB: begin
                    ram_write_en  = 1'b1;
                    ram_write_sel = 4'b1000 >> addr_q[1:0];
                    ram_data_in   = {4{sdata_q[7:0]}};
                end
                OP_SH: begin
                    ram_write_en  = 1'b1;
                    ram_write_sel = addr_q[1] ? 4'b0011 : 4'b1100;
                    ram_data_in   = {2{sdata_q[15:0]}};
                end
                OP_SW: begin
                    ram_write_en  = 1'b1;
                    ram_write_sel = 4'b1111;
                    ram_data_in   = sdata_q;
                end
                default: ;
            endcase
        end
    end

    // Big-endian lanes: byte offset k lives at bits [8*(3-k) +: 8].
    assign lane_shift = ram_data_out >> {~addr_q[1:0], 3'b000};
    assign sel_byte   = lane_shift[7:0];
    assign sel_half   = addr_q[1] ? ram_data_out[15:0] : ram_data_out[31:16];

    always_comb begin
        load_d = 32'd0;
        case (op_q)
            OP_LB:   load_d = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_d = {24'd0, sel_byte};
            OP_LH:   load_d = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_d = {16'd0, sel_half};
            OP_LW:   load_d = ram_data_out;
            default: load_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            op_q          <= 4'd0;
            addr_q        <= 32'd0;
            sdata_q       <= 32'd0;
            wd_q          <= 5'd0;
            wreg_q        <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_wd_q       <= 5'd0;
            wb_wreg_q     <= 1'b0;
            wb_wdata_q    <= 32'd0;
            wb_exc_q      <= 1'b0;
            wb_badvaddr_q <= 32'd0;
        end else if (flush) begin
            state_q    <= S_IDLE;
            wb_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if ((is_load || is_store) && !illegal) begin
                            state_q    <= S_ACCESS;
                            op_q       <= in_mem_op;
                            addr_q     <= in_addr;
                            sdata_q    <= in_store_data;
                            wd_q       <= in_wd;
                            wreg_q     <= in_wreg;
                            wb_valid_q <= 1'b0;
                        end else begin
                            wb_valid_q    <= 1'b1;
                            wb_wd_q       <= in_wd;
                            wb_wreg_q     <= illegal ? 1'b0 : in_wreg;
                            wb_wdata_q    <= in_wdata;
                            wb_exc_q      <= illegal;
                            wb_badvaddr_q <= illegal ? in_addr : 32'd0;
                        end
                    end else if (wb_valid_q && wb_ready) begin
                        wb_valid_q <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    state_q       <= S_IDLE;
                    wb_valid_q    <= 1'b1;
                    wb_wd_q       <= wd_q;
                    wb_wreg_q     <= store_q ? 1'b0 : wreg_q;
                    wb_wdata_q    <= store_q ? 32'd0 : load_d;
                    wb_exc_q      <= 1'b0;
                    wb_badvaddr_q <= 32'd0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_wd       = wb_wd_q;
    assign wb_wreg     = wb_wreg_q;
    assign wb_wdata    = wb_wdata_q;
    assign wb_exc      = wb_exc_q;
    assign wb_badvaddr = wb_badvaddr_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed vector bench for mem_stage with a behavioural data RAM
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_mem_op;
    logic [31:0] in_addr, in_store_data, in_wdata;
    logic [4:0]  in_wd;
    logic        in_wreg, flush;
    logic        ram_enable, ram_write_en;
    logic [3:0]  ram_write_sel;
    logic [31:0] ram_addr, ram_data_in, ram_data_out;
    logic        wb_valid, wb_ready, wb_wreg, wb_exc;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata, wb_badvaddr;

    mem_stage #(.WORD_DEPTH(512)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_op(in_mem_op), .in_addr(in_addr), .in_store_data(in_store_data),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata), .flush(flush),
        .ram_enable(ram_enable), .ram_write_en(ram_write_en), .ram_write_sel(ram_write_sel),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
        .wb_wdata(wb_wdata), .wb_exc(wb_exc), .wb_badvaddr(wb_badvaddr)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:511];
    logic        clr_mem;
    assign ram_data_out = mem[ram_addr[8:0]];

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'd0;
        end else if (ram_enable && ram_write_en) begin
            for (int k = 0; k < 4; k++)
                if (ram_write_sel[k]) mem[ram_addr[8:0]][8*k +: 8] <= ram_data_in[8*k +: 8];
        end
    end

    int          acc_cnt = 0, wr_cnt = 0;
    logic [3:0]  last_sel = 4'd0;
    logic [31:0] last_din = 32'd0, last_addr = 32'd0;
    always @(negedge clk) begin
        if (ram_enable) begin
            acc_cnt   <= acc_cnt + 1;
            last_addr <= ram_addr;
            if (ram_write_en) begin
                wr_cnt   <= wr_cnt + 1;
                last_sel <= ram_write_sel;
                last_din <= ram_data_in;
            end
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        int          lat;
        logic        exc;
        logic        ewreg;
        logic [31:0] ewdata;
        logic        chk_data;
        int          nacc;
        int          nwr;
        logic [3:0]  sel;
        logic [31:0] din;
        logic [31:0] raddr;
    } vec_t;

    function automatic vec_t ld(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] wd,
                                input logic [31:0] ewdata);
        vec_t v;
        v = '{op: op, addr: addr, sdata: 32'd0, wd: wd, wreg: 1'b1, wdata: 32'h0BAD0BAD, lat: 2,
              exc: 1'b0, ewreg: 1'b1, ewdata: ewdata, chk_data: 1'b1, nacc: 1, nwr: 0,
              sel: 4'd0, din: 32'd0, raddr: {2'b00, addr[31:2]}};
        return v;
    endfunction

    function automatic vec_t st(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [3:0] sel, input logic [31:0] din);
        vec_t v;
        v = '{op: op, addr: addr, sdata: sdata, wd: 5'd1, wreg: 1'b1, wdata: 32'd0, lat: 2,
              exc: 1'b0, ewreg: 1'b0, ewdata: 32'd0, chk_data: 1'b0, nacc: 1, nwr: 1,
              sel: sel, din: din, raddr: {2'b00, addr[31:2]}};
        return v;
    endfunction

    function automatic vec_t bad(input logic [3:0] op, input logic [31:0] addr);
        vec_t v;
        v = '{op: op, addr: addr, sdata: 32'h12345678, wd: 5'd6, wreg: 1'b1, wdata: 32'd0, lat: 1,
              exc: 1'b1, ewreg: 1'b0, ewdata: 32'd0, chk_data: 1'b0, nacc: 0, nwr: 0,
              sel: 4'd0, din: 32'd0, raddr: 32'd0};
        return v;
    endfunction

    function automatic vec_t nop(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                                 input logic [31:0] wdata);
        vec_t v;
        v = '{op: op, addr: 32'h10, sdata: 32'd0, wd: wd, wreg: wreg, wdata: wdata, lat: 1,
              exc: 1'b0, ewreg: wreg, ewdata: wdata, chk_data: 1'b1, nacc: 0, nwr: 0,
              sel: 4'd0, din: 32'd0, raddr: 32'd0};
        return v;
    endfunction

    task automatic apply(input string tag, input vec_t v);
        int lat, acc0, wr0;
        @(posedge clk);
        @(negedge clk);
        acc0 = acc_cnt;
        wr0  = wr_cnt;
        in_mem_op = v.op; in_addr = v.addr; in_store_data = v.sdata;
        in_wd = v.wd; in_wreg = v.wreg; in_wdata = v.wdata; in_valid = 1'b1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_mem_op = 4'd0;
        lat = 1;
        while (!wb_valid && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        chk({tag, " wb_exc"}, 32'(wb_exc), 32'(v.exc));
        chk({tag, " wb_wreg"}, 32'(wb_wreg), 32'(v.ewreg));
        chk({tag, " wb_wd"}, 32'(wb_wd), 32'(v.wd));
        chk({tag, " wb_badvaddr"}, wb_badvaddr, v.exc ? v.addr : 32'd0);
        if (v.chk_data) chk({tag, " wb_wdata"}, wb_wdata, v.ewdata);
        chk({tag, " ram accesses"}, 32'(acc_cnt - acc0), 32'(v.nacc));
        chk({tag, " ram writes"}, 32'(wr_cnt - wr0), 32'(v.nwr));
        if (v.nacc > 0) chk({tag, " ram_addr"}, last_addr, v.raddr);
        if (v.nwr > 0) begin
            chk({tag, " write_sel"}, 32'(last_sel), 32'(v.sel));
            chk({tag, " ram_data_in"}, last_din, v.din);
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(st(4'd8, 32'h10, 32'hA1B2C3D4, 4'b1111, 32'hA1B2C3D4));
        vecs.push_back(ld(4'd5, 32'h10, 5'd3, 32'hA1B2C3D4));
        vecs.push_back(st(4'd6, 32'h13, 32'h000000FF, 4'b0001, 32'hFFFFFFFF));
        vecs.push_back(ld(4'd1, 32'h13, 5'd4, 32'hFFFFFFFF));
        vecs.push_back(ld(4'd2, 32'h13, 5'd5, 32'h000000FF));
        vecs.push_back(bad(4'd3, 32'h21));
        vecs.push_back(ld(4'd1, 32'h10, 5'd10, 32'hFFFFFFA1));
        vecs.push_back(ld(4'd4, 32'h12, 5'd11, 32'h0000C3FF));
        vecs.push_back(ld(4'd3, 32'h10, 5'd12, 32'hFFFFA1B2));
        vecs.push_back(st(4'd7, 32'h22, 32'h12345678, 4'b0011, 32'h56785678));
        vecs.push_back(st(4'd7, 32'h20, 32'h0000ABCD, 4'b1100, 32'hABCDABCD));
        vecs.push_back(ld(4'd5, 32'h20, 5'd13, 32'hABCD5678));
        vecs.push_back(ld(4'd3, 32'h22, 5'd14, 32'h00005678));
        vecs.push_back(ld(4'd3, 32'h20, 5'd15, 32'hFFFFABCD));
        vecs.push_back(st(4'd6, 32'h21, 32'h00000077, 4'b0100, 32'h77777777));
        vecs.push_back(ld(4'd2, 32'h21, 5'd16, 32'h00000077));
        vecs.push_back(ld(4'd1, 32'h22, 5'd17, 32'h00000056));
        vecs.push_back(nop(4'd0, 5'd7, 1'b1, 32'hDEADBEEF));
        vecs.push_back(nop(4'd15, 5'd8, 1'b0, 32'h00000055));
        vecs.push_back(bad(4'd5, 32'h800));
        vecs.push_back(st(4'd8, 32'h7FC, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D));
        vecs.push_back(ld(4'd5, 32'h7FC, 5'd18, 32'hCAFEF00D));
        vecs.push_back(bad(4'd8, 32'h06));
        vecs.push_back(bad(4'd7, 32'h01));
        vecs.push_back(bad(4'd4, 32'h03));
        vecs.push_back(bad(4'd5, 32'h02));

        rst = 1'b0; clr_mem = 1'b1; flush = 1'b0; wb_ready = 1'b1; in_valid = 1'b0;
        in_mem_op = 4'd0; in_addr = 32'd0; in_store_data = 32'd0; in_wd = 5'd0; in_wreg = 1'b0; in_wdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset wb", {wb_valid, wb_exc, wb_wreg, wb_wd}, 32'd0);
        chk("reset ram ctl", {ram_enable, ram_write_en, ram_write_sel}, 32'd0);
        chk("reset ram_addr", ram_addr, 32'd0);
        rst = 1'b1; clr_mem = 1'b0;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) apply($sformatf("v%0d", i), vecs[i]);

        // Writeback backpressure on a load, with a second request waiting
        @(posedge clk);
        @(negedge clk);
        wb_ready = 1'b0;
        in_mem_op = 4'd5; in_addr = 32'h10; in_wd = 5'd9; in_wreg = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp wb_valid", 32'(wb_valid), 32'd1);
        chk("bp wb_wdata", wb_wdata, 32'hA1B2C3FF);
        begin
            int acc0;
            acc0 = acc_cnt;
            in_mem_op = 4'd0; in_wd = 5'd2; in_wreg = 1'b1; in_wdata = 32'h00001234; in_valid = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk($sformatf("bp stall%0d in_ready", c), 32'(in_ready), 32'd0);
                chk($sformatf("bp stall%0d wb", c), {wb_valid, wb_wreg, wb_wd}, {25'd0, 1'b1, 1'b1, 5'd9});
                chk($sformatf("bp stall%0d wdata", c), wb_wdata, 32'hA1B2C3FF);
            end
            chk("bp no extra access", 32'(acc_cnt - acc0), 32'd0);
        end
        wb_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp next wb", {wb_valid, wb_wreg, wb_wd}, {25'd0, 1'b1, 1'b1, 5'd2});
        chk("bp next wdata", wb_wdata, 32'h00001234);

        // Flush while a store sits in ACCESS
        @(posedge clk);
        @(negedge clk);
        begin
            int acc0, wr0;
            acc0 = acc_cnt; wr0 = wr_cnt;
            in_mem_op = 4'd8; in_addr = 32'h40; in_store_data = 32'h11111111; in_wd = 5'd0; in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0; flush = 1'b1;
            @(negedge clk);
            chk("flush ram_enable", 32'(ram_enable), 32'd0);
            chk("flush ram_write_en", 32'(ram_write_en), 32'd0);
            @(posedge clk);
            #1;
            flush = 1'b0;
            chk("flush wb_valid", 32'(wb_valid), 32'd0);
            @(negedge clk);
            chk("flush accesses", 32'(acc_cnt - acc0), 32'd0);
            chk("flush writes", 32'(wr_cnt - wr0), 32'd0);
            chk("flush mem", mem[16], 32'd0);
            @(posedge clk);
            #1;
            chk("flush wb_valid later", 32'(wb_valid), 32'd0);
        end

        // Asynchronous reset in the middle of a store's ACCESS cycle
        @(posedge clk);
        @(negedge clk);
        in_mem_op = 4'd8; in_addr = 32'h44; in_store_data = 32'h22222222; in_wd = 5'd5; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre-reset ram_enable", 32'(ram_enable), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async rst ram ctl", {ram_enable, ram_write_en, ram_write_sel, in_ready}, 32'd0);
        chk("async rst ram_addr", ram_addr, 32'd0);
        chk("async rst ram_data_in", ram_data_in, 32'd0);
        chk("async rst wb ctl", {wb_valid, wb_exc, wb_wreg, wb_wd}, 32'd0);
        chk("async rst wb_wdata", wb_wdata, 32'd0);
        chk("async rst wb_badvaddr", wb_badvaddr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("aborted store mem", mem[17], 32'd0);
        apply("after rst LW 0x44", ld(4'd5, 32'h44, 5'd20, 32'h00000000));
        apply("after flush LW 0x40", ld(4'd5, 32'h40, 5'd21, 32'h00000000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: WORD_DEPTH, 512, number of 32-bit words in the data RAM; legal word index 0..WORD_DEPTH-1.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  upstream (EX/MEM) request valid.
REQ-005 in_ready  out  1  stage accepts request this cycle.
REQ-006 in_mem_op  in  4  0000 none, 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW, 0110 SB, 0111 SH, 1000 SW; other codes = none.
REQ-007 in_addr  in  32  byte address (loads/stores).
REQ-008 in_store_data  in  32  store data, right-aligned.
REQ-009 in_wd / in_wreg / in_wdata  in  5/1/32  destination reg, write flag, ALU result.
REQ-010 flush  in  1  kill in-flight request.
REQ-011 ram_enable / ram_write_en / ram_write_sel  out  1/1/4  to data RAM.
REQ-012 ram_addr / ram_data_in  out  32/32  RAM word address, RAM write data.
REQ-013 ram_data_out  in  32  RAM combinational read data; lane 3 = [31:24].
REQ-014 wb_valid / wb_ready  out/in  1/1  writeback handshake.
REQ-015 wb_wd / wb_wreg / wb_wdata  out  5/1/32  writeback result.
REQ-016 wb_exc / wb_badvaddr  out  1/32  address-error flag and faulting byte address.

Function
REQ-017 Transfer occurs on posedge when in_valid && in_ready; in_ready = (state==IDLE) && (!wb_valid || wb_ready) && !flush.
REQ-018 FSM states IDLE, ACCESS; IDLE->ACCESS on accepted legal load/store; ACCESS->IDLE always after one cycle; flush forces IDLE.
REQ-019 Accepted op none, or illegal access: bypasses ACCESS; WB register loaded at acceptance edge (latency 1).
REQ-020 Illegal access: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; addr[31:2] >= WORD_DEPTH; result wb_exc=1, wb_badvaddr=in_addr, wb_wreg=0, no RAM access.
REQ-021 Legal load/store: request registered at acceptance; RAM driven only during ACCESS; WB register loaded at ACCESS-exit edge (latency 2).
REQ-022 ram_addr = {2'b00, addr[31:2]} during ACCESS, 0 otherwise; ram_enable = (state==ACCESS) && !flush.
REQ-023 Byte lane big-endian: offset k maps to lane 3-k.
REQ-024 SB: write_sel = 4'b1000 >> addr[1:0], ram_data_in = {4{data[7:0]}}.
REQ-025 SH: write_sel = 1100 (offset 0) / 0011 (offset 2), ram_data_in = {2{data[15:0]}}; SW: 1111, data unchanged.
REQ-026 Loads: ram_write_en=0, write_sel=0000; stores: ram_write_en=1, wb_wreg=0.
REQ-027 LB/LH sign-extend, LBU/LHU zero-extend the selected lane(s) sampled from ram_data_out during ACCESS; LW passes word.
REQ-028 Op none: wb_wdata=in_wdata, wb_wreg=in_wreg; wb_wd always from request.
REQ-029 WB register holds while wb_valid && !wb_ready; clears wb_valid on wb_valid && wb_ready with no new load.
REQ-030 ACCESS never stalls: in_ready rule guarantees WB slot free at ACCESS exit.
REQ-031 flush: clears wb_valid, returns to IDLE, gates ram_enable combinationally; store in ACCESS with flush=1 is not written.
REQ-032 Each store writes RAM exactly one cycle.

Reset
REQ-033 rst low asynchronously: state=IDLE, wb_valid=0, wb_exc=0, wb_wreg=0, wb_wd=0, wb_wdata=0, wb_badvaddr=0, all ram_* outputs 0.
REQ-034 Reset during ACCESS aborts request; pending store not written.
REQ-035 in_ready=0 while rst low; first acceptance on first edge after release.

Verification
REQ-036 SW addr=0x10 data=0xA1B2C3D4, then LW 0x10 -> write_sel=1111, ram_addr=4; load wb_wdata=0xA1B2C3D4 two cycles after accept.
REQ-037 SB addr=0x13 data=0x000000FF -> write_sel=0001, ram_data_in=0xFFFFFFFF; then LB 0x13 -> 0xFFFFFFFF, LBU 0x13 -> 0x000000FF.
REQ-038 LH addr=0x21 -> wb_exc=1, wb_badvaddr=0x21, wb_wreg=0, ram_enable never asserted, wb_valid one cycle after accept.
REQ-039 LW accepted, wb_ready=0 for 3 cycles -> wb outputs stable, in_ready=0, no second RAM access; release -> next request accepted same cycle.
REQ-040 SW in ACCESS with flush=1 -> ram_enable=0, memory unchanged, wb_valid=0 next cycle.
REQ-041 rst low mid-ACCESS -> all outputs 0 immediately without clock edge.
